// File: rtl/tree_node_pkg.sv
// Shared types for the tree-node dispatcher: FSM states and command modes.
package tree_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } node_state_e;

    typedef enum logic {
        BCAST = 1'b0,
        SEQ   = 1'b1
    } node_mode_e;

endpackage

// File: rtl/tree_node_timeout_ctr.sv
// Wait-cycle counter for one command step; expired is asserted when the count
// reaches a nonzero limit.
module tree_node_timeout_ctr #(
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= cnt + TIMEOUT_W'(1);
    end

    // A zero limit means wait forever.
    assign expired = (limit != '0) && (cnt == limit);

endmodule

// File: rtl/tree_node_dispatcher.sv
// Fans one parent command out to NUM_CHILD children (broadcast or in index
// order), gathers their acks and returns a single response, with optional timeout.
module tree_node_dispatcher
    import tree_node_pkg::*;
#(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DATA_W-1:0]    cmd_data,
    input  logic                 cmd_mode,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [NUM_CHILD-1:0] child_valid,
    output logic [DATA_W-1:0]    child_data,
    input  logic [NUM_CHILD-1:0] child_ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NUM_CHILD-1:0] rsp_ack_mask,
    output logic                 rsp_timeout
);

    localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

    node_state_e          state, state_nxt;
    node_mode_e           mode;
    logic [IDX_W-1:0]     idx;
    logic [NUM_CHILD-1:0] pending, ack_mask;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [NUM_CHILD-1:0] acc, pend_left;
    logic                 seq_last, done, step, abort;
    logic                 ctr_clear, ctr_en, expired;

    assign cmd_ready   = (state == IDLE);
    assign child_valid = pending;

    // pending is only nonzero in ISSUE, so acks elsewhere fall out here.
    assign acc       = child_ack & pending;
    assign pend_left = pending & ~acc;
    assign seq_last  = (idx == IDX_W'(NUM_CHILD - 1));

    tree_node_timeout_ctr #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .limit  (limit_q),
        .expired(expired)
    );

    always_comb begin
        state_nxt = state;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        done      = 1'b0;
        step      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ISSUE;
                    ctr_clear = 1'b1;
                end
            end
            ISSUE: begin
                ctr_en = 1'b1;
                if (mode == BCAST) begin
                    done = (pend_left == '0);
                end else if (acc != '0) begin
                    done = seq_last;
                    step = !seq_last;
                end
                // An ack landing on the limit cycle takes precedence over abort.
                abort     = expired && !done && !step;
                ctr_clear = step;
                if (done || abort) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mode         <= BCAST;
            idx          <= '0;
            pending      <= '0;
            ack_mask     <= '0;
            limit_q      <= '0;
            child_data   <= '0;
            rsp_valid    <= 1'b0;
            rsp_ack_mask <= '0;
            rsp_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        child_data <= cmd_data;
                        mode       <= node_mode_e'(cmd_mode);
                        limit_q    <= timeout_limit;
                        ack_mask   <= '0;
                        idx        <= '0;
                        pending    <= cmd_mode ? NUM_CHILD'(1) : {NUM_CHILD{1'b1}};
                    end
                end
                ISSUE: begin
                    ack_mask <= ack_mask | acc;
                    if (step) begin
                        idx     <= idx + IDX_W'(1);
                        pending <= pending << 1;
                    end else if (done || abort) begin
                        pending      <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_ack_mask <= ack_mask | acc;
                        rsp_timeout  <= abort;
                    end else begin
                        pending <= pend_left;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        rsp_ack_mask <= '0;
                        rsp_timeout  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_node_dispatcher.sv
// Self-checking bench: reactive child models with per-child ack delays, checked
// against a delay/limit arithmetic model of response latency, mask and timeout.
module tb_tree_node_dispatcher;

    localparam int NC    = 5;
    localparam int DW    = 16;
    localparam int TW    = 8;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_mode = 1'b0;
    logic [TW-1:0] timeout_limit = '0;
    logic [NC-1:0] child_valid;
    logic [DW-1:0] child_data;
    logic [NC-1:0] child_ack = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [NC-1:0] rsp_ack_mask;
    logic          rsp_timeout;

    int tests_run = 0;
    int fails = 0;
    int dly[NC];

    always #5 clk = ~clk;

    tree_node_dispatcher #(.NUM_CHILD(NC), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_mode(cmd_mode), .timeout_limit(timeout_limit),
        .child_valid(child_valid), .child_data(child_data), .child_ack(child_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ack_mask(rsp_ack_mask), .rsp_timeout(rsp_timeout)
    );

    // Child i acks once it has been addressed for dly[i] cycles. Broadcast:
    // all children start together and the limit bounds the whole command.
    // Sequential: each child gets its own window of up to lim+1 cycles.
    task automatic model(input bit mode, input int lim, output logic [NC-1:0] m,
                         output bit to, output int cyc, output logic [NC-1:0] seen);
        int len, mx;
        len = 0; mx = 0; m = '0; to = 0; seen = '0;
        if (!mode) begin
            seen = '1;
            for (int i = 0; i < NC; i++) begin
                if (lim == 0 || dly[i] <= lim) m[i] = 1'b1;
                if (dly[i] > mx) mx = dly[i];
            end
            if (m == '1) len = mx + 1;
            else begin len = lim + 1; to = 1; end
        end else begin
            for (int j = 0; j < NC; j++) begin
                seen[j] = 1'b1;
                if (lim == 0 || dly[j] <= lim) begin
                    len += dly[j] + 1;
                    m[j] = 1'b1;
                end else begin
                    len += lim + 1;
                    to = 1;
                    break;
                end
            end
        end
        cyc = len + 1;
    endtask

    task automatic run_cmd(input bit mode, input int lim, input int hold, input bit walk,
                           input string name);
        logic [NC-1:0] em, es, seen;
        logic [DW-1:0] d;
        bit eto, bad_data, bad_walk, bad_hold;
        int ecyc, c;
        int vcnt[NC];
        model(mode, lim, em, eto, ecyc, es);
        seen = '0; c = 0; bad_data = 0; bad_walk = 0; bad_hold = 0;
        d = DW'($urandom);
        for (int i = 0; i < NC; i++) vcnt[i] = 0;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_data = d; timeout_limit = TW'(lim);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_data = DW'($urandom); timeout_limit = TW'($urandom);
        while (1) begin
            @(negedge clk); c++;
            if (rsp_valid === 1'b1 || c > 300) begin child_ack = '0; break; end
            seen |= child_valid;
            if (child_valid != '0 && child_data !== d) bad_data = 1;
            if (walk && child_valid !== (NC'(1) << (c - 1))) bad_walk = 1;
            for (int i = 0; i < NC; i++) begin
                if (child_valid[i]) begin
                    child_ack[i] = (vcnt[i] >= dly[i]);
                    vcnt[i]++;
                end else begin
                    child_ack[i] = 1'($urandom_range(0, 1));
                    vcnt[i] = 0;
                end
            end
        end
        tests_run++;
        if (c !== ecyc) begin
            fails++; $display("FAIL %s latency: got cycle %0d want %0d", name, c, ecyc);
        end
        tests_run++;
        if (rsp_ack_mask !== em || rsp_timeout !== eto) begin
            fails++; $display("FAIL %s rsp: got mask %b to %b want mask %b to %b",
                              name, rsp_ack_mask, rsp_timeout, em, eto);
        end
        tests_run++;
        if (seen !== es || bad_data) begin
            fails++; $display("FAIL %s addressed: got %b data_err %0d want %b", name, seen, bad_data, es);
        end
        if (walk) begin
            tests_run++;
            if (bad_walk) begin fails++; $display("FAIL %s walk: child_valid order wrong", name); end
        end
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_ack_mask !== em || rsp_timeout !== eto) bad_hold = 1;
        end
        if (hold > 0) begin
            tests_run++;
            if (bad_hold) begin fails++; $display("FAIL %s hold: rsp changed while stalled", name); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL %s release: got rsp_valid %b cmd_ready %b want 0 1",
                              name, rsp_valid, cmd_ready);
        end
        if (c > 300) begin
            rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        end
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d, input int e);
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d; dly[4] = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || child_valid !== '0 || rsp_valid !== 1'b0 ||
            rsp_ack_mask !== '0 || rsp_timeout !== 1'b0 || child_data !== '0) begin
            fails++; $display("FAIL reset: rdy %b cv %b rv %b mask %b to %b data %h want 1 0 0 0 0 0",
                              cmd_ready, child_valid, rsp_valid, rsp_ack_mask, rsp_timeout, child_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_stray();
        bit bad;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            child_ack = '1;
            if (child_valid !== '0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1;
        end
        @(negedge clk);
        child_ack = '0;
        if (child_valid !== '0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1;
        tests_run++;
        if (bad) begin fails++; $display("FAIL idle_stray: got cv %b rv %b want 0 0", child_valid, rsp_valid); end
    endtask

    task automatic test_reset_mid_issue();
        bit bad;
        bad = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 1'($urandom_range(0, 1)); cmd_data = DW'($urandom);
        timeout_limit = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (child_valid === '0) begin fails++; $display("FAIL mid_issue: child_valid got 0 want nonzero"); end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (child_valid !== '0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL mid_reset: got cv %b rdy %b rv %b want 0 1 0",
                              child_valid, cmd_ready, rsp_valid);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || child_valid !== '0) bad = 1;
        end
        tests_run++;
        if (bad) begin fails++; $display("FAIL post_reset: response or request after abort"); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int lim;
            lim = $urandom_range(0, 5);
            for (int i = 0; i < NC; i++) begin
                dly[i] = $urandom_range(0, 6);
                if (lim != 0 && $urandom_range(0, 5) == 0) dly[i] = NEVER;
            end
            run_cmd(1'($urandom_range(0, 1)), lim, $urandom_range(0, 2), 0, "random");
        end
    endtask

    initial begin
        test_reset();
        set_dly(0, 0, 0, 0, 0);                run_cmd(0, 0, 0, 0, "bcast_all");
        set_dly(0, NEVER, 0, NEVER, 0);        run_cmd(0, 4, 0, 0, "bcast_partial");
        set_dly(0, 0, 0, 0, 0);                run_cmd(1, 0, 0, 1, "seq_walk");
        set_dly(0, 0, NEVER, 0, 0);            run_cmd(1, 3, 0, 0, "seq_silent");
        set_dly(0, 1, 3, 2, 3);                run_cmd(0, 3, 0, 0, "bcast_ack_at_limit");
        set_dly(0, 0, 0, 0, 2);                run_cmd(1, 2, 0, 0, "seq_ack_at_limit");
        test_idle_stray();
        set_dly(1, 0, 2, 0, NEVER);            run_cmd(0, 5, 3, 0, "rsp_hold");
        test_reset_mid_issue();
        set_dly(0, 0, 0, 0, 0);                run_cmd(0, 0, 0, 0, "after_reset");
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
